mem_request_queue: RTL and testbench

- Initiator-side front end to the data port of the cache.
- Buffers load/store operations from the load-store stage in a FIFO, issues the head entry over the cache data handshake, and returns load results tagged with their ROB id.
- Honours rob_clear: speculative loads are discarded; committed stores always complete.

---
 rtl/mem_request_queue.sv | 205 ++++++++++++++++++++
 tb/tb_mem_request_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_queue.sv
// Load/store request FIFO in front of the cache data port: issues the head entry
// over the need_data/data_ready handshake and returns tagged load results.
module mem_request_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear,
  input  logic             enq_valid,
  output logic             enq_full,
  input  logic             enq_is_write,
  input  logic [31:0]      enq_addr,
  input  logic [2:0]       enq_type,
  input  logic [31:0]      enq_wdata,
  input  logic [TAG_W-1:0] enq_tag,
  output logic             need_data,
  output logic             is_write,
  output logic [31:0]      data_addr,
  output logic [2:0]       work_type,
  output logic [31:0]      data_in,
  input  logic             data_ready,
  input  logic [31:0]      data_out,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_full;

  logic [DEPTH-1:0] r_ent_write;
  logic [DEPTH-1:0] r_ent_kill;
  logic [31:0]      r_ent_addr  [DEPTH];
  logic [2:0]       r_ent_type  [DEPTH];
  logic [31:0]      r_ent_wdata [DEPTH];
  logic [TAG_W-1:0] r_ent_tag   [DEPTH];

  logic             r_need_data;
  logic             r_is_write;
  logic [31:0]      r_data_addr;
  logic [2:0]       r_work_type;
  logic [31:0]      r_data_in;
  logic             r_res_valid;
  logic [TAG_W-1:0] r_res_tag;
  logic [31:0]      r_res_data;

  logic             w_not_empty;
  logic             w_pop;
  logic             w_issue;
  logic             w_result;
  logic             w_enq;
  logic [31:0]      w_wdata_masked;

  assign w_not_empty = (r_count != '0);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
    w_result     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_not_empty) begin
          if (r_ent_kill[r_head]) begin
            w_pop = 1'b1;
          end else begin
            w_issue      = 1'b1;
            w_state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (data_ready) begin
          w_pop        = 1'b1;
          w_state_next = S_GAP;
          // Kill bit covers earlier clears; rob_clear covers one landing with the completion.
          w_result     = !r_ent_write[r_head] && !r_ent_kill[r_head] && !rob_clear;
        end
      end
      S_GAP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // A pop in the same cycle frees a slot, so a full queue may still accept.
  assign w_enq = enq_valid && !rob_clear && ((r_count < FULL_CNT) || w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_enq && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (!w_enq && w_pop) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_wdata_masked = enq_wdata;
    case (enq_type[1:0])
      2'b00:   w_wdata_masked = {24'd0, enq_wdata[7:0]};
      2'b01:   w_wdata_masked = {16'd0, enq_wdata[15:0]};
      default: w_wdata_masked = enq_wdata;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_enq && rdy_in && !rst_in) begin
      r_ent_addr[r_tail]  <= enq_addr;
      r_ent_type[r_tail]  <= enq_type;
      r_ent_wdata[r_tail] <= w_wdata_masked;
      r_ent_tag[r_tail]   <= enq_tag;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_ent_write <= '0;
      r_ent_kill  <= '0;
      r_need_data <= 1'b0;
      r_is_write  <= 1'b0;
      r_data_addr <= '0;
      r_work_type <= '0;
      r_data_in   <= '0;
      r_res_valid <= 1'b0;
      r_res_tag   <= '0;
      r_res_data  <= '0;
    end else if (rdy_in) begin
      if (w_enq) begin
        r_ent_write[r_tail] <= enq_is_write;
        r_ent_kill[r_tail]  <= 1'b0;
        r_tail              <= r_tail + PTR_W'(1);
      end
      // Enqueue is blocked during a clear, so this never collides with the write above.
      if (rob_clear) begin
        r_ent_kill <= r_ent_kill | ~r_ent_write;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);

      if (w_issue) begin
        r_need_data <= 1'b1;
        r_is_write  <= r_ent_write[r_head];
        r_data_addr <= r_ent_addr[r_head];
        r_work_type <= r_ent_type[r_head];
        r_data_in   <= r_ent_wdata[r_head];
      end else if (r_state == S_REQ && data_ready) begin
        r_need_data <= 1'b0;
      end

      r_res_valid <= w_result;
      if (w_result) begin
        r_res_tag  <= r_ent_tag[r_head];
        r_res_data <= data_out;
      end
    end
  end

  assign enq_full  = r_full;
  assign need_data = r_need_data;
  assign is_write  = r_is_write;
  assign data_addr = r_data_addr;
  assign work_type = r_work_type;
  assign data_in   = r_data_in;
  assign res_valid = r_res_valid;
  assign res_tag   = r_res_tag;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_mem_request_queue.sv
// Directed self-checking bench for mem_request_queue (DEPTH=8, TAG_W=4).
module tb_mem_request_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear;
  logic        enq_valid;
  logic        enq_full;
  logic        enq_is_write;
  logic [31:0] enq_addr;
  logic [2:0]  enq_type;
  logic [31:0] enq_wdata;
  logic [3:0]  enq_tag;
  logic        need_data;
  logic        is_write;
  logic [31:0] data_addr;
  logic [2:0]  work_type;
  logic [31:0] data_in;
  logic        data_ready;
  logic [31:0] data_out;
  logic        res_valid;
  logic [3:0]  res_tag;
  logic [31:0] res_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mem_request_queue #(.DEPTH(8), .TAG_W(4)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .rob_clear    (rob_clear),
    .enq_valid    (enq_valid),
    .enq_full     (enq_full),
    .enq_is_write (enq_is_write),
    .enq_addr     (enq_addr),
    .enq_type     (enq_type),
    .enq_wdata    (enq_wdata),
    .enq_tag      (enq_tag),
    .need_data    (need_data),
    .is_write     (is_write),
    .data_addr    (data_addr),
    .work_type    (work_type),
    .data_in      (data_in),
    .data_ready   (data_ready),
    .data_out     (data_out),
    .res_valid    (res_valid),
    .res_tag      (res_tag),
    .res_data     (res_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present one enqueue for exactly one edge.
  task automatic enq(input logic wr, input logic [31:0] addr, input logic [2:0] typ,
                     input logic [31:0] wdata, input logic [3:0] tag);
    enq_valid    = 1'b1;
    enq_is_write = wr;
    enq_addr     = addr;
    enq_type     = typ;
    enq_wdata    = wdata;
    enq_tag      = tag;
    tick();
    enq_valid    = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (!need_data && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, need_data}, 32'd1);
  endtask

  // Complete the outstanding load and check its result on the following cycle.
  task automatic serve_load(input logic [3:0] tag, input logic [31:0] addr);
    wait_req("req_seen");
    check_eq("req_addr", data_addr, addr);
    check_eq("req_is_write", {31'd0, is_write}, 32'd0);
    data_ready = 1'b1;
    data_out   = 32'hC000_0000 | {28'd0, tag};
    tick();
    data_ready = 1'b0;
    data_out   = '0;
    check_eq("res_valid", {31'd0, res_valid}, 32'd1);
    check_eq("res_tag", {28'd0, res_tag}, {28'd0, tag});
    check_eq("res_data", res_data, 32'hC000_0000 | {28'd0, tag});
    check_eq("need_drop", {31'd0, need_data}, 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; enq_valid = 1'b0;
    enq_is_write = 1'b0; enq_addr = '0; enq_type = '0; enq_wdata = '0; enq_tag = '0;
    data_ready = 1'b0; data_out = '0;
    tick(); tick();
    rst_in = 1'b0;
    check_eq("rst_need", {31'd0, need_data}, 32'd0);
    check_eq("rst_full", {31'd0, enq_full}, 32'd0);
    check_eq("rst_resv", {31'd0, res_valid}, 32'd0);
    check_eq("rst_addr", data_addr, 32'd0);

    // Basic load with a 4-cycle cache latency.
    enq(1'b0, 32'h100, 3'b010, 32'd0, 4'd3);
    check_eq("ld_need_early", {31'd0, need_data}, 32'd0);
    tick();
    check_eq("ld_need", {31'd0, need_data}, 32'd1);
    check_eq("ld_addr", data_addr, 32'h100);
    check_eq("ld_type", {29'd0, work_type}, 32'd2);
    tick(); tick(); tick();
    check_eq("ld_hold", {31'd0, need_data}, 32'd1);
    data_ready = 1'b1; data_out = 32'hDEAD_BEEF;
    tick();
    data_ready = 1'b0; data_out = '0;
    check_eq("ld_resv", {31'd0, res_valid}, 32'd1);
    check_eq("ld_tag", {28'd0, res_tag}, 32'd3);
    check_eq("ld_data", res_data, 32'hDEAD_BEEF);
    check_eq("ld_gap", {31'd0, need_data}, 32'd0);
    tick();
    check_eq("ld_res_once", {31'd0, res_valid}, 32'd0);

    // Store byte masking.
    enq(1'b1, 32'h7, 3'b000, 32'h1234_5678, 4'd0);
    wait_req("st_seen");
    check_eq("st_is_write", {31'd0, is_write}, 32'd1);
    check_eq("st_data", data_in, 32'h0000_0078);
    check_eq("st_addr", data_addr, 32'h7);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check_eq("st_no_res", {31'd0, res_valid}, 32'd0);
    tick();

    // Fill to DEPTH, reject a 9th, then drain across the pointer wrap.
    for (int i = 0; i < 8; i++) begin
      enq(1'b0, 32'h200 + 32'(4 * i), 3'b010, 32'd0, 4'(i));
    end
    check_eq("full_set", {31'd0, enq_full}, 32'd1);
    enq(1'b0, 32'h2F0, 3'b010, 32'd0, 4'd15);
    check_eq("full_hold", {31'd0, enq_full}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      serve_load(4'(i), 32'h200 + 32'(4 * i));
    end
    check_eq("full_clr", {31'd0, enq_full}, 32'd0);
    for (int i = 8; i < 12; i++) begin
      enq(1'b0, 32'h200 + 32'(4 * i), 3'b010, 32'd0, 4'(i));
    end
    check_eq("refull", {31'd0, enq_full}, 32'd1);
    for (int i = 4; i < 12; i++) begin
      serve_load(4'(i), 32'h200 + 32'(4 * i));
    end
    for (int i = 0; i < 4; i++) tick();
    check_eq("drained", {31'd0, need_data}, 32'd0);

    // Flush: A in flight, store B survives, load C is skipped.
    enq(1'b0, 32'h300, 3'b010, 32'd0, 4'd1);
    enq(1'b1, 32'h304, 3'b010, 32'hAABB_CCDD, 4'd0);
    enq(1'b0, 32'h308, 3'b010, 32'd0, 4'd2);
    check_eq("fl_a_req", {31'd0, need_data}, 32'd1);
    rob_clear = 1'b1;
    tick();
    rob_clear = 1'b0;
    tick(); tick();
    check_eq("fl_a_hold", {31'd0, need_data}, 32'd1);
    check_eq("fl_a_addr", data_addr, 32'h300);
    data_ready = 1'b1; data_out = 32'h5555_5555;
    tick();
    data_ready = 1'b0; data_out = '0;
    check_eq("fl_a_nores", {31'd0, res_valid}, 32'd0);
    wait_req("fl_b_seen");
    check_eq("fl_b_addr", data_addr, 32'h304);
    check_eq("fl_b_wr", {31'd0, is_write}, 32'd1);
    check_eq("fl_b_data", data_in, 32'hAABB_CCDD);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check_eq("fl_b_nores", {31'd0, res_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("fl_c_skip", {31'd0, need_data}, 32'd0);
    end
    enq(1'b0, 32'h400, 3'b010, 32'd0, 4'd5);
    serve_load(4'd5, 32'h400);
    tick();

    // Clear coincident with data_ready; following store issues after the gap.
    enq(1'b0, 32'h500, 3'b010, 32'd0, 4'd6);
    enq(1'b1, 32'h504, 3'b001, 32'hFFFF_ABCD, 4'd0);
    wait_req("cc_seen");
    check_eq("cc_addr", data_addr, 32'h500);
    data_ready = 1'b1; rob_clear = 1'b1; data_out = 32'h7777_7777;
    tick();
    data_ready = 1'b0; rob_clear = 1'b0; data_out = '0;
    check_eq("cc_nores", {31'd0, res_valid}, 32'd0);
    check_eq("cc_gap", {31'd0, need_data}, 32'd0);
    tick();
    check_eq("cc_idle", {31'd0, need_data}, 32'd0);
    tick();
    check_eq("cc_next", {31'd0, need_data}, 32'd1);
    check_eq("cc_next_addr", data_addr, 32'h504);
    check_eq("cc_half_mask", data_in, 32'h0000_ABCD);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();

    // rdy_in low freezes a pending request even while data_ready is high.
    enq(1'b0, 32'h600, 3'b110, 32'd0, 4'd9);
    wait_req("rdy_seen");
    rdy_in = 1'b0; data_ready = 1'b1; data_out = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rdy_frz_need", {31'd0, need_data}, 32'd1);
      check_eq("rdy_frz_res", {31'd0, res_valid}, 32'd0);
    end
    rdy_in = 1'b1; data_ready = 1'b0; data_out = '0;
    tick();
    check_eq("rdy_still_req", {31'd0, need_data}, 32'd1);
    check_eq("rdy_type", {29'd0, work_type}, 32'd6);
    serve_load(4'd9, 32'h600);
    tick();

    // Reset mid-request, then an enqueue during rob_clear is dropped.
    enq(1'b0, 32'h700, 3'b010, 32'd0, 4'd4);
    wait_req("rst_req_seen");
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_eq("rst_mid_need", {31'd0, need_data}, 32'd0);
    rob_clear = 1'b1;
    enq(1'b0, 32'h800, 3'b010, 32'd0, 4'd8);
    rob_clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("empty_after", {31'd0, need_data}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
